// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline types: latch occupancy states and stage payload structs
//
// Contents:
//   latch_state_t : occupancy of a two-entry pipeline latch (EMPTY/HALF/FULL)
//   idex_t        : ID/EX stage payload bundle carried through pipe_latch
//   IDEX_W        : width of idex_t, used to size pipe_latch DATA_W
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } latch_state_t;

    // ID/EX bundle: decoded control plus register/immediate fields.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [15:0] imm;
    } idex_t;

    localparam int IDEX_W = $bits(idex_t);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears the count
//   inc : count one event this cycle
//   cnt : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_latch.sv
// rtl/pipe_latch.sv - two-entry skid pipeline latch with valid/ready handshake and flush
//
// Ports:
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   in_valid   : upstream presents a payload
//   in_data    : upstream payload (DATA_W bits, e.g. idex_t)
//   in_ready   : latch can accept a payload this cycle (registered decode only)
//   out_valid  : out_data holds a live payload
//   out_data   : payload to downstream (always the main register)
//   out_ready  : downstream consumes out_data this cycle
//   flush      : squash all held payloads
//   stall_cnt  : cycles with out_valid & !out_ready   (PIPE_LATCH_PERF_EN only)
//   bubble_cnt : cycles with !out_valid & !flush      (PIPE_LATCH_PERF_EN only)
//
// Build option: define PIPE_LATCH_PERF_EN to add the saturating performance counters.
module pipe_latch
    import cpu_types_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush
`ifdef PIPE_LATCH_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_latch: CNT_W must be at least 1");
    end

    latch_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              drain;

    // Both handshake outputs decode the state register alone, so in_ready
    // never depends combinationally on out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A concurrent drain has already been seen downstream; a concurrent
            // accept is simply dropped. Data registers keep stale contents.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = HALF;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_LATCH_PERF_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (CLK),
        .rst (RST),
        .inc (out_valid & ~out_ready),
        .cnt (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (CLK),
        .rst (RST),
        .inc (~out_valid & ~flush),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_latch.sv
// tb/tb_pipe_latch.sv - directed vector bench for pipe_latch
module tb_pipe_latch;
    import cpu_types_pkg::*;

    localparam int DW = IDEX_W;
    localparam int CW = 4;
    localparam logic [DW-1:0] RV = 32'hDEAD_BEEF;

    logic          CLK;
    logic          RST;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          flush;
`ifdef PIPE_LATCH_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    pipe_latch #(
        .DATA_W    (DW),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush      (flush)
`ifdef PIPE_LATCH_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string         name;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic          er;
        logic          chk_d;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(string name, logic iv, logic [DW-1:0] d, logic ordy, logic fl,
                                logic ev, logic er, logic chk_d, logic [DW-1:0] ed);
        vec_t v;
        v.name = name; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.er = er; v.chk_d = chk_d; v.ed = ed;
        return v;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic [DW-1:0] d, logic ordy, logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Apply one vector across one clock edge, then check outputs 1 time unit later.
    task automatic apply(vec_t v);
        drive(v.iv, v.d, v.ordy, v.fl);
        @(posedge CLK);
        #1;
        chk({v.name, ".out_valid"}, DW'(out_valid), DW'(v.ev));
        chk({v.name, ".in_ready"},  DW'(in_ready),  DW'(v.er));
        if (v.chk_d) chk({v.name, ".out_data"}, out_data, v.ed);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Reset state (RESET_VAL = DEADBEEF)
        chk("rst.out_data",  out_data, 32'hDEADBEEF);
        chk("rst.out_valid", DW'(out_valid), DW'(0));
        chk("rst.in_ready",  DW'(in_ready), DW'(1));

        // Streaming 1..8 with out_ready=1: each appears one edge after accept
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk($sformatf("stream%0d", i), 1, DW'(i), 1, 0, 1, 1, 1, DW'(i)));
        end
        vecs.push_back(mk("stream_drain", 0, '0, 1, 0, 0, 1, 0, '0));
        // Fill to FULL with out_ready=0, then drain in order
        vecs.push_back(mk("fillA",      1, 32'hA,  0, 0, 1, 1, 1, 32'hA));
        vecs.push_back(mk("fillB",      1, 32'hB,  0, 0, 1, 0, 1, 32'hA));
        vecs.push_back(mk("full_hold",  1, 32'h99, 0, 0, 1, 0, 1, 32'hA));
        vecs.push_back(mk("drainA",     0, '0,     1, 0, 1, 1, 1, 32'hB));
        vecs.push_back(mk("drainB",     0, '0,     1, 0, 0, 1, 0, '0));
        // FULL then flush with a concurrent payload 0xC
        vecs.push_back(mk("f_fill1",    1, 32'h11, 0, 0, 1, 1, 1, 32'h11));
        vecs.push_back(mk("f_fill2",    1, 32'h12, 0, 0, 1, 0, 1, 32'h11));
        vecs.push_back(mk("flushC",     1, 32'hC,  0, 1, 0, 1, 0, '0));
        vecs.push_back(mk("post_flush", 0, '0,     1, 0, 0, 1, 0, '0));
        vecs.push_back(mk("after_fl",   1, 32'h13, 1, 0, 1, 1, 1, 32'h13));
        vecs.push_back(mk("after_fl_d", 0, '0,     1, 0, 0, 1, 0, '0));
        // Flush in HALF with a concurrent drain
        vecs.push_back(mk("h_load",     1, 32'h14, 0, 0, 1, 1, 1, 32'h14));
        vecs.push_back(mk("h_flush_dr", 0, '0,     1, 1, 0, 1, 0, '0));
        vecs.push_back(mk("idle_empty", 0, '0,     0, 0, 0, 1, 0, '0));

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset mid-cycle while FULL
        apply(mk("r_fill1", 1, 32'h31, 0, 0, 1, 1, 1, 32'h31));
        apply(mk("r_fill2", 1, 32'h32, 0, 0, 1, 0, 1, 32'h31));
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst.out_valid", DW'(out_valid), DW'(0));
        chk("async_rst.in_ready",  DW'(in_ready), DW'(1));
        chk("async_rst.out_data",  out_data, 32'hDEADBEEF);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        apply(mk("post_rst_acc",   1, 32'h21, 0, 0, 1, 1, 1, 32'h21));
        apply(mk("post_rst_drain", 0, '0,     1, 0, 0, 1, 0, '0));
        apply(mk("post_rst_idle",  0, '0,     1, 0, 0, 1, 0, '0));

`ifdef PIPE_LATCH_PERF_EN
        // Counters: clear, 3 idle cycles, then hold a payload with out_ready=0
        RST = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("perf_rst.stall",  DW'(stall_cnt), DW'(0));
        chk("perf_rst.bubble", DW'(bubble_cnt), DW'(0));
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("perf_idle.bubble", DW'(bubble_cnt), DW'(3));
        chk("perf_idle.stall",  DW'(stall_cnt), DW'(0));
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (20) @(posedge CLK);
        #1;
        chk("perf_stall.stall",  DW'(stall_cnt), DW'(4'hF));
        chk("perf_stall.bubble", DW'(bubble_cnt), DW'(4));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
